// File: rtl/sap_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : sap_ctrl_seq
// Description : Control sequencer for the 8-bit SAP datapath. Steps a T-state
//               ring through fetch (T1-T3) and execute (T4-T6), decoding the
//               opcode in ir[7:4] into one-hot datapath control strobes.
//               Optional macro SAP_CTRL_VARLEN_EN: each instruction returns
//               to T1 right after its last active T-state instead of always
//               padding out to T6.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_ctrl_seq #(
    parameter int T_MAX = 6,
    parameter int OPW   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_oe,
    output logic       mar_ld,
    output logic       mem_oe,
    output logic       mem_we,
    output logic       ir_ld,
    output logic       ir_oe,
    output logic       a_ld,
    output logic       a_oe,
    output logic       b_ld,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       flags_ld,
    output logic       out_ld,
    output logic       halted,
    output logic       instr_done,
    output logic [2:0] tstate
);

    // HALT encodes as 0 so tstate can be the raw state value
    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6
    } state_t;

    localparam logic [OPW-1:0] c_OP_LDA = OPW'(4'h1);
    localparam logic [OPW-1:0] c_OP_ADD = OPW'(4'h2);
    localparam logic [OPW-1:0] c_OP_SUB = OPW'(4'h3);
    localparam logic [OPW-1:0] c_OP_STA = OPW'(4'h4);
    localparam logic [OPW-1:0] c_OP_LDI = OPW'(4'h5);
    localparam logic [OPW-1:0] c_OP_JMP = OPW'(4'h6);
    localparam logic [OPW-1:0] c_OP_JC  = OPW'(4'h7);
    localparam logic [OPW-1:0] c_OP_JZ  = OPW'(4'h8);
    localparam logic [OPW-1:0] c_OP_OUT = OPW'(4'hE);
    localparam logic [OPW-1:0] c_OP_HLT = OPW'(4'hF);

    state_t         r_state;
    state_t         w_next;
    state_t         w_last_t;
    logic [OPW-1:0] w_op;
    logic           w_active;

    assign w_op     = ir[7 -: OPW];
    // Strobes are forced low while reset is held, while stalled and in HALT
    assign w_active = reset && run && (r_state != S_HALT);
    assign tstate   = r_state;
    assign halted   = (r_state == S_HALT);

    // Final T-state of the current instruction
    always_comb begin
        w_last_t = S_T6;
`ifdef SAP_CTRL_VARLEN_EN
        if ((w_op == c_OP_LDA) || (w_op == c_OP_STA))
            w_last_t = S_T5;
        else if ((w_op == c_OP_ADD) || (w_op == c_OP_SUB))
            w_last_t = S_T6;
        else
            w_last_t = S_T4;
`endif
    end

    // State register: async active-low reset returns to T1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_T1;
        else
            r_state <= w_next;
    end

    // Next-state: advance only while running; HALT is a sink left only by reset
    always_comb begin
        w_next = r_state;
        if (run) begin
            if (r_state == S_HALT)
                w_next = S_HALT;
            else if ((r_state == S_T4) && (w_op == c_OP_HLT))
                w_next = S_HALT;
            else if (r_state == w_last_t)
                w_next = S_T1;
            else
                w_next = state_t'(r_state + 3'd1);
        end
    end

    // Strobe decode from current T-state, opcode and flags
    always_comb begin
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_oe      = 1'b0;
        mar_ld     = 1'b0;
        mem_oe     = 1'b0;
        mem_we     = 1'b0;
        ir_ld      = 1'b0;
        ir_oe      = 1'b0;
        a_ld       = 1'b0;
        a_oe       = 1'b0;
        b_ld       = 1'b0;
        alu_oe     = 1'b0;
        alu_sub    = 1'b0;
        flags_ld   = 1'b0;
        out_ld     = 1'b0;
        instr_done = 1'b0;
        if (w_active) begin
            instr_done = (r_state == w_last_t) ||
                         ((r_state == S_T4) && (w_op == c_OP_HLT));
            case (r_state)
                S_T1: begin
                    pc_oe  = 1'b1;
                    mar_ld = 1'b1;
                end
                S_T2: pc_inc = 1'b1;
                S_T3: begin
                    mem_oe = 1'b1;
                    ir_ld  = 1'b1;
                end
                S_T4: begin
                    case (w_op)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                            ir_oe  = 1'b1;
                            mar_ld = 1'b1;
                        end
                        c_OP_LDI: begin
                            ir_oe = 1'b1;
                            a_ld  = 1'b1;
                        end
                        c_OP_JMP: begin
                            ir_oe   = 1'b1;
                            pc_load = 1'b1;
                        end
                        c_OP_JC: begin
                            ir_oe   = 1'b1;
                            pc_load = flag_c;
                        end
                        c_OP_JZ: begin
                            ir_oe   = 1'b1;
                            pc_load = flag_z;
                        end
                        c_OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ld = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (w_op)
                        c_OP_LDA: begin
                            mem_oe = 1'b1;
                            a_ld   = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            mem_oe = 1'b1;
                            b_ld   = 1'b1;
                        end
                        c_OP_STA: begin
                            a_oe   = 1'b1;
                            mem_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    if ((w_op == c_OP_ADD) || (w_op == c_OP_SUB)) begin
                        alu_oe   = 1'b1;
                        a_ld     = 1'b1;
                        flags_ld = 1'b1;
                        alu_sub  = (w_op == c_OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // Structural guarantees of the decode
    a_pc_excl: assert property (@(posedge clk) disable iff (!reset)
                                !(pc_inc && pc_load));
    a_one_drv: assert property (@(posedge clk) disable iff (!reset)
                                $onehot0({pc_oe, mem_oe, ir_oe, a_oe, alu_oe}));
    a_tmax:    assert property (@(posedge clk) T_MAX == 6);

endmodule
`default_nettype wire

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
- Control sequencer for the 8-bit SAP datapath. Steps a T-state ring through fetch and execute, and decodes the opcode held in the instruction register.
- Emits one-hot control strobes to the program counter (inc/load), MAR, RAM, IR, A/B registers, ALU, flags and output register.
- Sole owner of the PC inc/load lines. The PC itself is unchanged: the counter increments on inc and loads d on load, and load has priority.

Parameters:
- T_MAX, 6, number of T-states in a fixed-length instruction cycle (legal value 6 only; kept for documentation and assertions).
- OPW, 4, opcode width taken from ir[7:4]; the operand is ir[3:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = sequencer advances; 0 = state frozen and all strobes low.
- ir  in  8  instruction register contents.
- flag_c  in  1  carry flag from the flags register.
- flag_z  in  1  zero flag from the flags register.
- pc_inc, pc_load, pc_oe  out  1 each  PC increment, load and bus-drive.
- mar_ld  out  1  MAR captures bus.
- mem_oe, mem_we  out  1 each  RAM read-drive and write.
- ir_ld, ir_oe  out  1 each  IR capture; IR drives {4'h0, ir[3:0]} on the bus.
- a_ld, a_oe, b_ld  out  1 each  A load, A drive, B load.
- alu_oe, alu_sub, flags_ld  out  1 each  ALU drive, subtract select, flags capture.
- out_ld  out  1  output register capture.
- halted  out  1  high in the HALT state.
- instr_done  out  1  high during the final T-state of each instruction.
- tstate  out  3  current T-state, 1..6; 0 in HALT.

Behaviour:
- Moore style: the state register is updated on posedge clk; strobes are decoded from the current state, ir and flags. A strobe asserted in Tn is acted on by the target register at the edge that ends Tn.
- Reset (reset=0, async): state=T1, tstate=1, halted=0, and every strobe is 0 immediately. Reset asserted mid-instruction aborts the instruction and returns to T1.
- run=0: state holds and all strobes read 0. On re-enable the sequencer continues from the same T-state; no inc or load is repeated.
- Fetch, common to all opcodes:
  - T1: pc_oe, mar_ld.
  - T2: pc_inc.
  - T3: mem_oe, ir_ld.
- Execute (T4/T5/T6; a blank entry means no strobes):
  - 0x0 NOP: -/-/-
  - 0x1 LDA: ir_oe+mar_ld / mem_oe+a_ld / -
  - 0x2 ADD: ir_oe+mar_ld / mem_oe+b_ld / alu_oe+a_ld+flags_ld
  - 0x3 SUB: as ADD, with alu_sub also high in T6
  - 0x4 STA: ir_oe+mar_ld / a_oe+mem_we / -
  - 0x5 LDI: ir_oe+a_ld / - / -
  - 0x6 JMP: ir_oe+pc_load / - / -
  - 0x7 JC: ir_oe, plus pc_load only if flag_c=1, in T4
  - 0x8 JZ: ir_oe, plus pc_load only if flag_z=1, in T4
  - 0xE OUT: a_oe+out_ld / - / -
  - 0xF HLT: in T4 the next state is HALT
  - 0x9-0xD (undefined): treated as NOP
- Transitions: T1→T2→…→T6→T1. From HALT, only reset exits; all strobes are 0, halted=1, tstate=0.
- pc_inc and pc_load are never high in the same cycle; this is guaranteed by decode.
- At most one bus driver is active per cycle (pc_oe, mem_oe, ir_oe, a_oe, alu_oe).
- instr_done is high in T6, or in the VARLEN_EN final state. For HLT it is high in T4.
- Flags are sampled combinationally in T4 for JC/JZ. A change on flag_c/flag_z outside T4 has no effect.

Optional Feature:
- Macro: SAP_CTRL_VARLEN_EN.
- Defined: after an instruction's last active T-state, the next state is T1 and instr_done is asserted in that state.
  - Lengths: LDA=5, STA=5, ADD=6, SUB=6, LDI/JMP/JC/JZ/OUT/NOP/undefined=4 (the empty T4 is kept).
- Undefined: every instruction takes 6 T-states; T-states with no strobes are padding.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release, run=1 → tstate=1 and pc_oe=mar_ld=1 in the first cycle; pc_inc=1 in cycle 2; ir_ld=1 in cycle 3.
- Reset mid-instruction: ir=0x25 (ADD 5), pull reset low during T5 → all strobes 0 immediately; after release, tstate=1 and b_ld never pulses.
- LDI then OUT: ir=0x5A → T4 shows ir_oe=1, a_ld=1; next instruction ir=0xE0 → T4 shows a_oe=1, out_ld=1; exactly one pc_inc per instruction.
- JZ with flag_z=1: ir=0x8F → T4 shows pc_load=1, ir_oe=1. Repeat with flag_z=0 → pc_load=0. Paired with the PC, q=0x0F vs q=previous value+1.
- Stall and halt:
  - ir=0x12 with run=0 during T5 for 3 cycles → tstate stays 5, all strobes 0; after resume, mem_oe+a_ld fire once.
  - ir=0xF0 → halted=1, tstate=0 thereafter, and pc_inc never asserts again.
- Length: count cycles per instruction for LDI (4 with SAP_CTRL_VARLEN_EN, 6 without) and ADD (6 in both builds).
